ball_motion_ctrl: RTL and testbench
===================================

# ball_motion_ctrl

Computes the ball's top-left position once per video frame from the four direction buttons and drives `next_x`/`next_y` into the graphics stage. The graphics stage registers these coordinates and renders the ball from them. The block sits between the board button inputs / VGA sync generator and the graphics stage. It synchronises and debounces the buttons, derives a single-cycle frame tick from the pixel counters, and moves the ball by a fixed step with screen-edge clamping.

## Interface
Parameters:
- `H_DISP`, 640, visible pixels per line
- `V_DISP`, 480, visible lines per frame
- `BALL_SIZE`, 50, ball bounding-box edge in pixels
- `STEP`, 2, pixels moved per frame per axis (1..BALL_SIZE)
- `DEB_CYCLES`, 250000, clk cycles a synchronised button level must be stable before it is accepted

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `u`, `d`, `l`, `r`  in  1 each  raw, asynchronous push buttons (1 = pressed)
- `pix_x`, `pix_y`  in  10 each  current pixel coordinates from the sync generator; each may hold for several clk cycles
- `next_x`, `next_y`  out  10 each  registered ball top-left position
- `frame_tick`  out  1  registered one-cycle pulse, once per frame

## Operation
- Buttons: 2-FF synchroniser, then debounce. The debounced level changes only after the synchronised input differs from it for `DEB_CYCLES` consecutive cycles. Any mismatch shorter than that restarts the counter.
- Frame tick: `match = (pix_x == 0) && (pix_y == V_DISP)`, which is the first blanking line. `frame_tick` fires on the rising edge of `match` only, so a held coordinate yields one pulse.
- Bounds: `X_MAX = H_DISP - BALL_SIZE` (590), `Y_MAX = V_DISP - BALL_SIZE` (430). Arithmetic is 11-bit signed internally, so no wrap occurs.
- Per axis on each tick:
  - only `r`: `x = min(x + STEP, X_MAX)`
  - only `l`: `x = max(x - STEP, 0)`
  - both or neither: x unchanged
  - Y axis uses `d`/`u` identically with `Y_MAX`.
- Axes are independent, so diagonal movement is legal.
- Positions never leave `[0, X_MAX]` × `[0, Y_MAX]`.

## Timing
- Reset values (immediate, asynchronous):
  - `next_x = 0`, `next_y = 0`, `frame_tick = 0`
  - debounced levels 0, counters 0
  - bounce velocity (+x, +y)
- Button latency: 2 sync cycles + `DEB_CYCLES` until the debounced level changes.
- `match` rises in cycle N → `frame_tick` = 1 in cycle N+1 only.
- `next_x`/`next_y` take new values at the clock edge ending cycle N+1, so they are valid from N+2 until the next update.
- A button change coinciding with the tick edge uses the debounced level sampled in cycle N+1.
- Reset asserted mid-frame: all state returns to reset values. A tick pending from a `match` already high at deassertion is suppressed, because the edge detector's previous value resets to 1.

## Configuration
- Macro `BALL_AUTO_BOUNCE_EN`.
- Defined:
  - When no button is held on an axis, that axis moves autonomously by `STEP` per tick in its velocity direction.
  - If the step would cross a bound, the position clamps to the bound and that axis velocity inverts on the same tick.
  - Buttons held on an axis override autonomous motion for that axis and leave its velocity unchanged.
  - Velocity resets to (+x, +y).
- Undefined: no velocity registers exist; the ball moves only on buttons.

## Structure
- Shared package `vga_pkg` holds `H_DISP`, `V_DISP`, `BALL_SIZE` and derived `X_MAX`/`Y_MAX`, plus a 10-bit coordinate typedef. The graphics stage and sync generator use the same package.
- One sub-module, `button_debounce` (sync + counter, parameter `DEB_CYCLES`), instantiated four times.
- Frame-tick detection and position update live in the top.

## Test plan
- Reset check:
  - Stimulus: `reset` low mid-run.
  - Required: `next_x = next_y = 0` and `frame_tick = 0` immediately, without a clock edge.
- Move right:
  - Stimulus: `DEB_CYCLES = 4`, `STEP = 4`; hold `r` across 3 ticks.
  - Required: `next_x` = 4, 8, 12, each appearing 2 cycles after its `match` rise.
- Clamp:
  - Stimulus: `x = 588`, `r` held for 2 ticks.
  - Required: `next_x` = 590, 590.
  - Stimulus: `y = 1`, `u` held.
  - Required: `next_y` = 0.
- Conflict and debounce:
  - Stimulus: `u` and `d` both held.
  - Required: `next_y` unchanged.
  - Stimulus: 3-cycle glitch on `l` with `DEB_CYCLES = 4`.
  - Required: no movement.
- Tick uniqueness:
  - Stimulus: `pix_x = 0`, `pix_y = 480` held for 4 cycles.
  - Required: exactly one `frame_tick` pulse.
- Bounce (`BALL_AUTO_BOUNCE_EN`):
  - Stimulus: `x = 586`, vx = +, `STEP = 4`, no buttons.
  - Required: `next_x` = 590 → 586 → 582.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA geometry for the sync generator, ball motion and graphics stages.
// Also provides the clamped single-axis step used by the ball mover.
package vga_pkg;

    localparam int H_DISP    = 640;
    localparam int V_DISP    = 480;
    localparam int BALL_SIZE = 50;
    localparam int X_MAX     = H_DISP - BALL_SIZE;
    localparam int Y_MAX     = V_DISP - BALL_SIZE;

    typedef logic [9:0] coord_t;

    // 11-bit signed arithmetic so a step below 0 or past the limit never wraps
    function automatic coord_t move(input coord_t pos, input logic dir_up,
                                    input logic signed [10:0] step,
                                    input logic signed [10:0] lim);
        logic signed [10:0] p;
        p = dir_up ? (signed'({1'b0, pos}) + step) : (signed'({1'b0, pos}) - step);
        if (p > lim)
            p = lim;
        else if (p < 11'sd0)
            p = 11'sd0;
        return coord_t'(p[9:0]);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output level
// follows the synchronised button only after DEB_CYCLES consecutive mismatches.
module button_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position update from debounced direction buttons, clamped to the screen.
// Define BALL_AUTO_BOUNCE_EN to let idle axes drift and bounce off the edges.
module ball_motion_ctrl #(
    parameter int H_DISP     = vga_pkg::H_DISP,
    parameter int V_DISP     = vga_pkg::V_DISP,
    parameter int BALL_SIZE  = vga_pkg::BALL_SIZE,
    parameter int STEP       = 2,
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       u,
    input  logic       d,
    input  logic       l,
    input  logic       r,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       frame_tick
);

    import vga_pkg::*;

    localparam logic signed [10:0] X_LIM  = 11'(H_DISP - BALL_SIZE);
    localparam logic signed [10:0] Y_LIM  = 11'(V_DISP - BALL_SIZE);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    logic   u_db, d_db, l_db, r_db;
    logic   match, match_prev;
    coord_t x_d, y_d;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_u (.clk(clk), .reset(reset), .btn(u), .level(u_db));
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_d (.clk(clk), .reset(reset), .btn(d), .level(d_db));
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (.clk(clk), .reset(reset), .btn(l), .level(l_db));
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (.clk(clk), .reset(reset), .btn(r), .level(r_db));

    assign match = (pix_x == 10'd0) && (pix_y == 10'(V_DISP));

    // match_prev resets high so a match already present at reset release is not a new frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_prev <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            match_prev <= match;
            frame_tick <= match && !match_prev;
        end
    end

`ifdef BALL_AUTO_BOUNCE_EN
    logic vx_q, vx_d, vy_q, vy_d;
`endif

    always_comb begin
        x_d = next_x;
        y_d = next_y;
`ifdef BALL_AUTO_BOUNCE_EN
        vx_d = vx_q;
        vy_d = vy_q;
`endif
        if (r_db && !l_db)
            x_d = move(next_x, 1'b1, STEP_S, X_LIM);
        else if (l_db && !r_db)
            x_d = move(next_x, 1'b0, STEP_S, X_LIM);
`ifdef BALL_AUTO_BOUNCE_EN
        else if (!r_db && !l_db) begin
            x_d = move(next_x, vx_q, STEP_S, X_LIM);
            if (x_d == (vx_q ? X_LIM[9:0] : 10'd0))
                vx_d = ~vx_q;
        end
`endif

        if (d_db && !u_db)
            y_d = move(next_y, 1'b1, STEP_S, Y_LIM);
        else if (u_db && !d_db)
            y_d = move(next_y, 1'b0, STEP_S, Y_LIM);
`ifdef BALL_AUTO_BOUNCE_EN
        else if (!d_db && !u_db) begin
            y_d = move(next_y, vy_q, STEP_S, Y_LIM);
            if (y_d == (vy_q ? Y_LIM[9:0] : 10'd0))
                vy_d = ~vy_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_x <= '0;
            next_y <= '0;
`ifdef BALL_AUTO_BOUNCE_EN
            vx_q   <= 1'b1;
            vy_q   <= 1'b1;
`endif
        end else if (frame_tick) begin
            next_x <= x_d;
            next_y <= y_d;
`ifdef BALL_AUTO_BOUNCE_EN
            vx_q   <= vx_d;
            vy_q   <= vy_d;
`endif
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl with short debounce and 4-pixel steps.
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       u, d, l, r;
    logic [9:0] pix_x, pix_y;
    logic [9:0] next_x, next_y;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cur_x  = 0;
    int cur_y  = 0;
    int pulses;

    ball_motion_ctrl #(
        .STEP(4),
        .DEB_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset),
        .u(u), .d(d), .l(l), .r(r),
        .pix_x(pix_x), .pix_y(pix_y),
        .next_x(next_x), .next_y(next_y),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one frame: match high for one cycle, then check tick timing and new position
    task automatic do_tick(input string tag, input int ex, input int ey);
        @(posedge clk); #1;
        pix_x = 10'd0; pix_y = 10'd480;
        @(posedge clk); #1;
        pix_x = 10'd5; pix_y = 10'd100;
        @(negedge clk);
        chk({tag, "_tick"}, 32'(frame_tick), 32'd1);
        chk({tag, "_xhold"}, 32'(next_x), 32'(cur_x));
        @(negedge clk);
        chk({tag, "_tick_low"}, 32'(frame_tick), 32'd0);
        chk({tag, "_x"}, 32'(next_x), 32'(ex));
        chk({tag, "_y"}, 32'(next_y), 32'(ey));
        cur_x = ex;
        cur_y = ey;
    endtask

    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {u, d, l, r} = 4'b0000;
        pix_x = 10'd5;
        pix_y = 10'd100;
        #12;
        chk("reset_x", 32'(next_x), 32'd0);
        chk("reset_y", 32'(next_y), 32'd0);
        chk("reset_tick", 32'(frame_tick), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

`ifdef BALL_AUTO_BOUNCE_EN
        for (int i = 1; i <= 150; i++) begin
            int ex, ey;
            if (i <= 147)      ex = 4 * i;
            else if (i == 148) ex = 590;
            else if (i == 149) ex = 586;
            else               ex = 582;
            if (i <= 107)      ey = 4 * i;
            else               ey = 430 - 4 * (i - 108);
            do_tick("bounce", ex, ey);
        end
`else
        r = 1'b1;
        settle();
        do_tick("right1", 4, 0);
        do_tick("right2", 8, 0);
        do_tick("right3", 12, 0);
        for (int i = 4; i <= 147; i++)
            do_tick("run_right", 4 * i, 0);
        do_tick("clamp_hi1", 590, 0);
        do_tick("clamp_hi2", 590, 0);

        r = 1'b0;
        d = 1'b1;
        settle();
        do_tick("down1", 590, 4);
        do_tick("down2", 590, 8);

        u = 1'b1;
        settle();
        do_tick("conflict", 590, 8);

        d = 1'b0;
        settle();
        do_tick("up1", 590, 4);
        do_tick("clamp_lo1", 590, 0);
        do_tick("clamp_lo2", 590, 0);

        u = 1'b0;
        settle();
        l = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        l = 1'b0;
        settle();
        do_tick("glitch", 590, 0);

        l = 1'b1;
        settle();
        do_tick("left", 586, 0);

        // match held for four cycles must give exactly one pulse
        pulses = 0;
        @(posedge clk); #1;
        pix_x = 10'd0; pix_y = 10'd480;
        repeat (4) begin
            @(negedge clk);
            if (frame_tick) pulses++;
            @(posedge clk);
        end
        #1;
        pix_x = 10'd5; pix_y = 10'd100;
        repeat (4) begin
            @(negedge clk);
            if (frame_tick) pulses++;
        end
        chk("uniq_pulses", 32'(pulses), 32'd1);
        chk("uniq_x", 32'(next_x), 32'd582);
        cur_x = 582;

        l = 1'b0;
        settle();

        // asynchronous reset while a tick is high
        @(posedge clk); #1;
        pix_x = 10'd0; pix_y = 10'd480;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("midreset_x", 32'(next_x), 32'd0);
        chk("midreset_y", 32'(next_y), 32'd0);
        chk("midreset_tick", 32'(frame_tick), 32'd0);
        cur_x = 0;
        cur_y = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (frame_tick) pulses++;
        end
        chk("suppress_pulses", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        pix_x = 10'd5; pix_y = 10'd100;
        do_tick("after_reset", 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
